// File: rtl/main_mem_arbiter_pkg.sv
// Shared definitions for the main memory path: default RAM geometry and the
// arbiter state encoding used by the processor, RAM wrappers and arbiter.
package main_mem_arbiter_pkg;

    localparam int unsigned DefAddrW = 12;
    localparam int unsigned DefDataW = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLockA = 2'd1,
        StLockB = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive refused cycles; hit flags that the
// refusal count has reached LIMIT.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4,
    localparam int unsigned CntW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [CntW-1:0] LimitVal = CntW'(LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign hit = (cnt_q >= LimitVal);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !hit) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM. Port A has
// priority, port B is protected from starvation, and either port may lock.
module main_mem_arbiter
    import main_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_wren,
    input  logic [DATA_W-1:0] m_q
);

    arb_state_e        state_q, state_d;
    logic              starve_hit;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              a_rd_q, b_rd_q;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (b_req && !b_gnt),
        .clr   (!b_req || b_gnt),
        .hit   (starve_hit)
    );

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        state_d = state_q;
        if (!reset) begin
            case (state_q)
                StIdle: begin
                    if (b_req && starve_hit) begin
                        b_gnt = 1'b1;
                    end else if (a_req) begin
                        a_gnt = 1'b1;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                    end
                    if (a_gnt && a_lock) begin
                        state_d = StLockA;
                    end else if (b_gnt && b_lock) begin
                        state_d = StLockB;
                    end
                end
                StLockA: begin
                    a_gnt = a_req;
                    if (!a_req || !a_lock) begin
                        state_d = StIdle;
                    end
                end
                StLockB: begin
                    b_gnt = b_req;
                    if (!b_req || !b_lock) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Without a grant the RAM bus keeps its last address and data.
    always_comb begin
        m_addr = addr_q;
        m_data = data_q;
        m_wren = 1'b0;
        if (a_gnt) begin
            m_addr = a_addr;
            m_data = a_wdata;
            m_wren = a_we;
        end else if (b_gnt) begin
            m_addr = b_addr;
            m_data = b_wdata;
            m_wren = b_we;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            a_rd_q  <= 1'b0;
            b_rd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (a_gnt || b_gnt) begin
                addr_q <= m_addr;
                data_q <= m_data;
            end
            a_rd_q <= a_gnt && !a_we;
            b_rd_q <= b_gnt && !b_we;
        end
    end

    // RAM data arrives one cycle after the address, so it is steered directly.
    assign a_rvalid = a_rd_q;
    assign b_rvalid = b_rd_q;
    assign a_rdata  = a_rd_q ? m_q : '0;
    assign b_rdata  = b_rd_q ? m_q : '0;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a behavioural RAM; read data is
// checked by a monitor against per-port queues of expected values.
module tb_main_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [11:0] a_addr, b_addr, m_addr;
    logic [15:0] a_wdata, b_wdata, m_data, m_q, a_rdata, b_rdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, m_wren;

    logic [15:0] mem [0:4095];
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int          checks = 0;
    int          errors = 0;
    bit          pat_a [8];

    main_mem_arbiter #(
        .ADDR_W       (12),
        .DATA_W       (16),
        .STARVE_LIMIT (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_lock   (a_lock),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_lock   (b_lock),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_wren   (m_wren),
        .m_q      (m_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (m_wren) mem[m_addr] <= m_data;
        m_q <= mem[m_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_gnt(input string name, input bit ea, input bit eb);
        @(negedge clock);
        chk({name, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, ea});
        chk({name, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, eb});
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    endtask

    // Monitor: every rvalid must match the oldest expectation for its port.
    initial begin
        forever begin
            @(negedge clock);
            chk("gnt_exclusive", {31'd0, a_gnt & b_gnt}, 32'd0);
            if (a_rvalid) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_rvalid_unexpected: got rdata %h expected no rvalid", a_rdata);
                end else begin
                    chk("a_rdata", {16'd0, a_rdata}, {16'd0, qa.pop_front()});
                end
            end
            if (b_rvalid) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_rvalid_unexpected: got rdata %h expected no rvalid", b_rdata);
                end else begin
                    chk("b_rdata", {16'd0, b_rdata}, {16'd0, qb.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h001] = 16'h1111;
        mem[12'h002] = 16'h2222;
        mem[12'h003] = 16'h3333;
        mem[12'h010] = 16'h1234;
        mem[12'h020] = 16'h0BAD;
        idle_inputs();
        reset = 1;

        // Reset state, with a request that must not be granted.
        a_req = 1; a_we = 1;
        @(negedge clock);
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_m_wren", {31'd0, m_wren}, 32'd0);
        chk("rst_m_addr", {20'd0, m_addr}, 32'd0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        step();
        reset = 0;
        idle_inputs();
        step();

        // Single read by A.
        a_req = 1; a_addr = 12'h010;
        expect_gnt("rd_a", 1, 0);
        chk("rd_a_m_addr", {20'd0, m_addr}, 32'h010);
        qa.push_back(16'h1234);
        step();
        idle_inputs();
        @(negedge clock);
        chk("hold_m_addr", {20'd0, m_addr}, 32'h010);
        chk("hold_m_wren", {31'd0, m_wren}, 32'd0);
        step();

        // Both requesting: A four times, then B via starvation, then A.
        pat_a = '{1, 1, 1, 1, 0, 1, 0, 0};
        a_req = 1; a_addr = 12'h001; b_req = 1; b_addr = 12'h002;
        for (int i = 0; i < 6; i++) begin
            expect_gnt($sformatf("starve%0d", i), pat_a[i], !pat_a[i]);
            if (pat_a[i]) qa.push_back(16'h1111);
            else qb.push_back(16'h2222);
            step();
        end
        idle_inputs();
        step();

        // B locks after winning by starvation, reads then writes 0x020.
        a_req = 1; a_addr = 12'h003; b_req = 1; b_lock = 1; b_addr = 12'h020;
        for (int i = 0; i < 5; i++) begin
            expect_gnt($sformatf("lockb%0d", i), i < 4, i == 4);
            if (i < 4) qa.push_back(16'h3333);
            else qb.push_back(16'h0BAD);
            step();
        end
        b_we = 1; b_wdata = 16'hBEEF; b_lock = 0;
        expect_gnt("lockb_wr", 0, 1);
        chk("lockb_wr_wren", {31'd0, m_wren}, 32'd1);
        chk("lockb_wr_data", {16'd0, m_data}, 32'hBEEF);
        step();
        b_req = 0; b_we = 0;
        expect_gnt("lockb_release", 1, 0);
        qa.push_back(16'h3333);
        step();
        idle_inputs();
        step();

        // A writes, B reads it back next cycle, then B reads the locked write.
        a_req = 1; a_we = 1; a_addr = 12'h005; a_wdata = 16'h00FF;
        expect_gnt("wr_a", 1, 0);
        chk("wr_a_wren", {31'd0, m_wren}, 32'd1);
        chk("wr_a_addr", {20'd0, m_addr}, 32'h005);
        step();
        idle_inputs();
        b_req = 1; b_addr = 12'h005;
        expect_gnt("rd_b5", 0, 1);
        qb.push_back(16'h00FF);
        step();
        b_addr = 12'h020; b_wdata = 16'hC0DE;
        expect_gnt("rd_b20", 0, 1);
        qb.push_back(16'hBEEF);
        step();
        idle_inputs();
        @(negedge clock);
        chk("hold_m_data", {16'd0, m_data}, 32'hC0DE);
        step();

        // A locks: B is held off past the limit, then wins right after release.
        a_req = 1; a_lock = 1; a_addr = 12'h001; b_req = 1; b_addr = 12'h002;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) a_lock = 0;
            expect_gnt($sformatf("locka%0d", i), i < 7, i == 7);
            if (i < 7) qa.push_back(16'h1111);
            else qb.push_back(16'h2222);
            step();
        end
        idle_inputs();
        step();

        // Reset the cycle after a locked read grant: the read is discarded.
        a_req = 1; a_lock = 1; a_addr = 12'h010;
        expect_gnt("rd_rst", 1, 0);
        qa.push_back(16'h1234);
        @(posedge clock);
        #1;
        reset = 1;
        a_we = 1;
        qa.delete();
        #1;
        chk("mid_rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("mid_rst_m_wren", {31'd0, m_wren}, 32'd0);
        chk("mid_rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("mid_rst_a_rdata", {16'd0, a_rdata}, 32'd0);
        chk("mid_rst_m_addr", {20'd0, m_addr}, 32'd0);
        chk("mid_rst_m_data", {16'd0, m_data}, 32'd0);
        step();
        step();
        reset = 0;
        idle_inputs();
        b_req = 1; b_addr = 12'h005;
        expect_gnt("post_rst_b", 0, 1);
        qb.push_back(16'h00FF);
        step();
        idle_inputs();
        step();
        step();
        step();

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 12, RAM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive cycles port B may be refused before it is forced to win.
REQ-004 The block SHALL have these ports, one clock and one asynchronous active-high reset, named as follows:
  clock      in   1       system clock, rising edge
  reset      in   1       asynchronous, active-high
  a_req      in   1       port A (processor) access request
  a_we       in   1       port A write enable
  a_lock     in   1       port A holds ownership after the current grant
  a_addr     in   ADDR_W  port A address
  a_wdata    in   DATA_W  port A write data
  a_gnt      out  1       port A access accepted this cycle
  a_rvalid   out  1       port A read data valid
  a_rdata    out  DATA_W  port A read data
  b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B (loader/debug)
  m_addr     out  ADDR_W  RAM address
  m_data     out  DATA_W  RAM write data
  m_wren     out  1       RAM write enable
  m_q        in   DATA_W  RAM read data, valid one clock after the address is presented

Function
REQ-005 At most one of a_gnt and b_gnt SHALL be high in any cycle.
REQ-006 Grants SHALL be combinational from req and the registered state, and a_gnt SHALL never be high without a_req (b likewise).
REQ-007 In the granted cycle, m_addr, m_data and m_wren SHALL equal the winner's addr, wdata and we.
REQ-008 With no grant, m_wren SHALL be 0, and m_addr and m_data SHALL hold their last driven values.
REQ-009 A granted read (we=0) SHALL assert the winner's rvalid for exactly one cycle, one cycle later, with rdata = m_q.
REQ-010 A granted write SHALL produce no rvalid.
REQ-011 The FSM SHALL have the states IDLE, LOCK_A and LOCK_B.
REQ-012 In IDLE, priority SHALL be port A, except port B SHALL win when starve_cnt >= STARVE_LIMIT.
REQ-013 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle b_req=1 and b_gnt=0, and SHALL clear on b_gnt or when b_req=0.
REQ-014 A grant with lock=1 SHALL move the FSM to LOCK_<winner>.
REQ-015 In LOCK_X, only port X SHALL be grantable, and the starvation override SHALL be suppressed.
REQ-016 In LOCK_X, the FSM SHALL return to IDLE on the first cycle X_req=0 or X_lock=0; the grant in that cycle, if X_req=1, still goes to X.
REQ-017 When both ports request in a cycle and neither override nor lock applies, A SHALL win and B SHALL wait (no request dropping; the requester holds its signals until gnt).
REQ-018 An rvalid in flight SHALL be delivered regardless of FSM transitions in the same cycle.

Reset
REQ-019 Asserting reset SHALL immediately force: state IDLE, starve_cnt 0, a_rvalid and b_rvalid 0, a_rdata and b_rdata 0, m_addr 0, m_data 0.
REQ-020 Grants SHALL be 0 while reset is high.
REQ-021 Reset during an outstanding read SHALL discard it, with no rvalid after release.
REQ-022 The first cycle after reset release SHALL arbitrate normally.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE=0, LOCK_A=1, LOCK_B=2) and the default ADDR_W/DATA_W constants used by processor, RAM wrappers and this block.
REQ-024 One sub-module SHALL be used: arb_starve_counter, a saturating counter with inc, clr, limit and hit outputs.
REQ-025 The rest SHALL be flat: grant logic, FSM register, read-return pipeline register.

Verification
REQ-026 a_req read at addr 0x010 with RAM[0x010]=0x1234 -> a_gnt the same cycle; a_rvalid=1, a_rdata=0x1234 one cycle later, for one cycle only.
REQ-027 a_req and b_req held high continuously, STARVE_LIMIT=4 -> A granted 4 cycles, B granted on the 5th, then A again; no cycle with both grants.
REQ-028 b_lock=1 with B doing read 0x020 then write 0x020=0xBEEF, a_req high throughout -> B granted both cycles, A granted the cycle after b_lock falls; RAM[0x020]=0xBEEF.
REQ-029 A write 0x005=0x00FF, then B read 0x005 next cycle -> b_rdata=0x00FF; a_rvalid stays 0.
REQ-030 Reset asserted mid-read (cycle after the grant) -> no rvalid, state IDLE, m_wren=0 immediately; after release, a single b_req gets b_gnt in its first cycle.
